// File: rtl/sisc_ctrl_mc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sisc_ctrl_mc_if                                                 |
// | Purpose  : Bundles the SISC controller's datapath-facing signals: the IR   |
// |            fields, status flags and memory-ready inputs, plus every        |
// |            datapath control strobe the controller produces.                |
// | Modports : master - the controller (drives the control strobes)           |
// |            slave  - the datapath (drives opcode/mm/stat/mem_rdy)           |
// | Signals  : opcode[OPW], mm[STW], stat[STW], mem_rdy               -> ctrl   |
// |            rf_we wb_sel br_sel pc_rst pc_write pc_sel ir_load rb_sel       |
// |            mm_sel dm_we dm_req sp_push sp_pop ret_sel alu_op[4]  <- ctrl   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface sisc_ctrl_mc_if #(
  parameter int OPW = 4,
  parameter int STW = 4
);
  // Instruction / status side
  logic [OPW-1:0] opcode;
  logic [STW-1:0] mm;
  logic [STW-1:0] stat;
  logic           mem_rdy;

  // Datapath control side
  logic           rf_we;
  logic           wb_sel;
  logic           br_sel;
  logic           pc_rst;
  logic           pc_write;
  logic           pc_sel;
  logic           ir_load;
  logic           rb_sel;
  logic           mm_sel;
  logic           dm_we;
  logic [3:0]     alu_op;
  logic           dm_req;
  logic           sp_push;
  logic           sp_pop;
  logic           ret_sel;

  modport master (
    input  opcode, mm, stat, mem_rdy,
    output rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load,
           rb_sel, mm_sel, dm_we, alu_op, dm_req, sp_push, sp_pop, ret_sel
  );

  modport slave (
    output opcode, mm, stat, mem_rdy,
    input  rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load,
           rb_sel, mm_sel, dm_we, alu_op, dm_req, sp_push, sp_pop, ret_sel
  );

endinterface
`default_nettype wire

// File: rtl/sisc_ctrl_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sisc_ctrl_mc                                                    |
// | Purpose  : Multi-cycle control FSM for the SISC datapath. Variable-length  |
// |            instruction paths (branches/jumps retire from DECODE), a data   |
// |            memory ready handshake with timeout, a real HALT state, a       |
// |            retired-instruction counter and optional CALL/RET stack control.|
// | Ports    : clk      in   clock, rising edge                                 |
// |            rst_f    in   asynchronous active-low reset                      |
// |            bus      ifc  sisc_ctrl_mc_if.master (IR fields, stat, mem_rdy,  |
// |                          all datapath control strobes)                     |
// |            halted   out  controller sits in HALT                           |
// |            fault    out  sticky error (MEM timeout, opcode 14, stack error) |
// |            instret  out  retired-instruction count, wraps mod 2^CNTW       |
// | Options  : CTRL_CALLRET_EN - when defined, CALL/RET drive the return-stack  |
// |            controls and a depth counter guards overflow/underflow; when    |
// |            undefined CALL/RET behave as NOOP and the stack strobes are 0.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sisc_ctrl_mc #(
  parameter int OPW       = 4,
  parameter int STW       = 4,
  parameter int MEM_TO    = 15,
  parameter int STK_DEPTH = 8,
  parameter int CNTW      = 16
) (
  input  logic            clk,
  input  logic            rst_f,
  sisc_ctrl_mc_if.master  bus,
  output logic            halted,
  output logic            fault,
  output logic [CNTW-1:0] instret
);

  // --------------------------------------------------------------------------
  // Opcode map
  // --------------------------------------------------------------------------
  localparam logic [OPW-1:0] c_op_noop   = OPW'(0);
  localparam logic [OPW-1:0] c_op_reg_op = OPW'(1);
  localparam logic [OPW-1:0] c_op_reg_im = OPW'(2);
  localparam logic [OPW-1:0] c_op_swap   = OPW'(3);
  localparam logic [OPW-1:0] c_op_bra    = OPW'(4);
  localparam logic [OPW-1:0] c_op_brr    = OPW'(5);
  localparam logic [OPW-1:0] c_op_bne    = OPW'(6);
  localparam logic [OPW-1:0] c_op_bnr    = OPW'(7);
  localparam logic [OPW-1:0] c_op_jpa    = OPW'(8);
  localparam logic [OPW-1:0] c_op_jpr    = OPW'(9);
  localparam logic [OPW-1:0] c_op_lod    = OPW'(10);
  localparam logic [OPW-1:0] c_op_str    = OPW'(11);
  localparam logic [OPW-1:0] c_op_call   = OPW'(12);
  localparam logic [OPW-1:0] c_op_ret    = OPW'(13);
  localparam logic [OPW-1:0] c_op_rsv    = OPW'(14);
  localparam logic [OPW-1:0] c_op_hlt    = OPW'(15);

  // Wait counter only has to reach MEM_TO-1 before the timeout fires.
  localparam int             c_tw      = $clog2(MEM_TO + 1);
  localparam logic [c_tw-1:0] c_wait_last = c_tw'(MEM_TO - 1);

  typedef enum logic [2:0] {
    S_START     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [c_tw-1:0]   r_wait;
  logic              r_fault;
  logic [CNTW-1:0]   r_instret;
  logic              w_fault_set;
  logic              w_is_mem;
  logic              w_cond;
  logic              w_pos_br;

  assign w_is_mem = (bus.opcode == c_op_lod) || (bus.opcode == c_op_str);
  // Any selected status flag set
  assign w_cond   = |(bus.mm & bus.stat);
  // BRA/BRR branch on flag set; BNE/BNR branch on flag clear
  assign w_pos_br = (bus.opcode == c_op_bra) || (bus.opcode == c_op_brr);

`ifdef CTRL_CALLRET_EN
  localparam int              c_dw        = $clog2(STK_DEPTH + 1);
  localparam logic [c_dw-1:0] c_depth_max = c_dw'(STK_DEPTH);

  logic [c_dw-1:0] r_depth;

  // Push/pop strobes are only raised from DECODE after the bound check,
  // so the counter can never leave 0..STK_DEPTH.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_depth <= '0;
    end else if (bus.sp_push) begin
      r_depth <= r_depth + c_dw'(1);
    end else if (bus.sp_pop) begin
      r_depth <= r_depth - c_dw'(1);
    end
  end
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state <= S_START;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next       = r_state;
    w_fault_set  = 1'b0;
    halted       = 1'b0;
    bus.rf_we    = 1'b0;
    bus.wb_sel   = 1'b0;
    bus.br_sel   = 1'b0;
    bus.pc_rst   = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.ir_load  = 1'b0;
    bus.rb_sel   = 1'b0;
    bus.mm_sel   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.alu_op   = 4'd0;
    bus.dm_req   = 1'b0;
    bus.sp_push  = 1'b0;
    bus.sp_pop   = 1'b0;
    bus.ret_sel  = 1'b0;

    case (r_state)
      S_START: begin
        bus.pc_rst = 1'b1;
        w_next     = S_FETCH;
      end

      S_FETCH: begin
        bus.ir_load  = 1'b1;
        bus.pc_write = 1'b1;
        w_next       = S_DECODE;
      end

      S_DECODE: begin
        bus.pc_sel = 1'b1;
        case (bus.opcode)
          c_op_noop: begin
            w_next = S_FETCH;
          end
          c_op_bra, c_op_brr, c_op_bne, c_op_bnr: begin
            bus.br_sel   = (bus.opcode == c_op_bra) || (bus.opcode == c_op_bne);
            // An empty mask makes every conditional branch unconditional.
            bus.pc_write = (bus.mm == '0) || (w_pos_br ? w_cond : ~w_cond);
            w_next       = S_FETCH;
          end
          c_op_jpa, c_op_jpr: begin
            bus.br_sel   = (bus.opcode == c_op_jpa);
            bus.pc_write = 1'b1;
            w_next       = S_FETCH;
          end
          c_op_call: begin
`ifdef CTRL_CALLRET_EN
            bus.br_sel = 1'b1;
            if (r_depth == c_depth_max) begin
              w_fault_set = 1'b1;
              w_next      = S_HALT;
            end else begin
              bus.pc_write = 1'b1;
              bus.sp_push  = 1'b1;
              w_next       = S_FETCH;
            end
`else
            w_next = S_FETCH;
`endif
          end
          c_op_ret: begin
`ifdef CTRL_CALLRET_EN
            if (r_depth == '0) begin
              w_fault_set = 1'b1;
              w_next      = S_HALT;
            end else begin
              bus.ret_sel  = 1'b1;
              bus.pc_write = 1'b1;
              bus.sp_pop   = 1'b1;
              w_next       = S_FETCH;
            end
`else
            w_next = S_FETCH;
`endif
          end
          c_op_hlt: begin
            w_next = S_HALT;
          end
          c_op_rsv: begin
            w_fault_set = 1'b1;
            w_next      = S_HALT;
          end
          default: begin
            w_next = S_EXECUTE;
          end
        endcase
      end

      S_EXECUTE: begin
        case (bus.opcode)
          c_op_reg_op:        bus.alu_op = 4'd1;
          c_op_reg_im:        bus.alu_op = 4'd3;
          c_op_swap:          bus.alu_op = 4'd5;
          c_op_lod, c_op_str: bus.alu_op = 4'd4;
          default:            bus.alu_op = 4'd0;
        endcase
        bus.rb_sel = (bus.opcode == c_op_str);
        w_next     = S_MEM;
      end

      S_MEM: begin
        case (bus.opcode)
          c_op_reg_op:        bus.alu_op = 4'd0;
          c_op_reg_im:        bus.alu_op = 4'd2;
          c_op_swap:          bus.alu_op = 4'd5;
          c_op_lod, c_op_str: bus.alu_op = 4'd4;
          default:            bus.alu_op = 4'd0;
        endcase
        bus.mm_sel = ~bus.mm[STW-1];
        if (w_is_mem) begin
          // Request and write strobes stay flat for the whole wait.
          bus.dm_req = 1'b1;
          bus.dm_we  = (bus.opcode == c_op_str);
          bus.rb_sel = (bus.opcode == c_op_str);
          if (bus.mem_rdy) begin
            w_next = S_WRITEBACK;
          end else if (r_wait == c_wait_last) begin
            w_fault_set = 1'b1;
            w_next      = S_HALT;
          end
        end else begin
          w_next = S_WRITEBACK;
        end
      end

      S_WRITEBACK: begin
        bus.rf_we  = (bus.opcode == c_op_reg_op) || (bus.opcode == c_op_reg_im) ||
                     (bus.opcode == c_op_swap)   || (bus.opcode == c_op_lod);
        bus.wb_sel = (bus.opcode == c_op_lod);
        bus.mm_sel = ~bus.mm[STW-1];
        w_next     = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        w_next = S_START;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // MEM wait counter, sticky fault, retired-instruction counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_wait <= '0;
    end else if (r_state != S_MEM) begin
      // Held at zero outside MEM so each access starts a fresh count.
      r_wait <= '0;
    end else if (w_is_mem && !bus.mem_rdy) begin
      r_wait <= r_wait + c_tw'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_instret <= '0;
    end else if (((r_state == S_DECODE) || (r_state == S_WRITEBACK)) &&
                 (w_next == S_FETCH)) begin
      r_instret <= r_instret + CNTW'(1);
    end
  end

  assign fault   = r_fault;
  assign instret = r_instret;

endmodule
`default_nettype wire
